multitap_delay_scale: RTL and testbench

Parametrised multi-tap delay line for the ambient-noise path: each accepted sample is written into a circular history buffer, and the output is the saturated sum of NUM_TAPS delayed copies, each weighted by a signed fixed-point gain. Taps are evaluated serially, one per clock, through a single multiply-accumulate. The block sits between the sample source and the cancellation mixer and models multi-path/passive attenuation. It replaces the single-tap, unsigned-gain delay stage.

---
 rtl/delay_pkg.sv | 40 ++++
 rtl/delay_history_ram.sv | 28 ++
 rtl/multitap_delay_scale.sv | 183 ++++++++++++++++++
 tb/tb_multitap_delay_scale.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the multi-tap delay/scale stage.
// Covers state encoding, derived widths and output saturation.
package delay_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ACCUM,
        OUT
    } state_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Extra headroom bits guarantee the tap sum can never wrap.
    function automatic int acc_width(input int width, input int scale_w, input int num_taps);
        return width + scale_w + $clog2(num_taps + 1);
    endfunction

    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                     input int                 frac_bits,
                                                     input int                 width);
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] result;
        shifted = value >>> frac_bits;
        max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (width - 1));
        result  = shifted;
        if (shifted > max_v) begin
            result = max_v;
        end else if (shifted < min_v) begin
            result = min_v;
        end
        return result;
    endfunction

endpackage

// File: rtl/delay_history_ram.sv
// Sample history store: one write port and one registered read port,
// written so synthesis can map it onto block RAM.
module delay_history_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/multitap_delay_scale.sv
// Multi-tap delay line: stores accepted samples in a circular history and
// outputs the saturated sum of gain-weighted delayed copies, one tap per clock.
module multitap_delay_scale
    import delay_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 256,
    parameter int NUM_TAPS  = 4,
    parameter int SCALE_W   = 8,
    parameter int FRAC_BITS = 6
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  ready_in,
    input  logic [WIDTH-1:0]                      signal_in,
    input  logic [NUM_TAPS*addr_width(DEPTH)-1:0] delay_in,
    input  logic [NUM_TAPS*SCALE_W-1:0]           scale_in,
    input  logic [NUM_TAPS-1:0]                   tap_en_in,
    output logic [WIDTH-1:0]                      signal_out,
    output logic                                  done_out,
    output logic                                  busy_out,
    output logic                                  overrun_out
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int ACC_W  = acc_width(WIDTH, SCALE_W, NUM_TAPS);
    localparam int PROD_W = WIDTH + SCALE_W;
    localparam int IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IDX_W-1:0]  LAST_TAP  = IDX_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0]         wr_ptr;
    logic [ADDR_W-1:0]         clr_addr;
    logic [ADDR_W-1:0]         base_q;
    logic [ADDR_W-1:0]         delay_q [NUM_TAPS];
    logic signed [SCALE_W-1:0] scale_q [NUM_TAPS];
    logic [NUM_TAPS-1:0]       en_q;
    logic [IDX_W-1:0]          issue_idx;
    logic [IDX_W-1:0]          acc_idx;
    logic                      issuing;
    logic                      acc_valid;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  product;
    logic [WIDTH-1:0]          result_sat;

    logic                      ram_we;
    logic                      ram_re;
    logic [ADDR_W-1:0]         ram_waddr;
    logic [ADDR_W-1:0]         ram_raddr;
    logic [WIDTH-1:0]          ram_wdata;
    logic signed [WIDTH-1:0]   ram_rdata;

    delay_history_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_history (
        .clk_in  (clk_in),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) next_state = IDLE;
            IDLE:    if (ready_in) next_state = ACCUM;
            ACCUM:   if (acc_valid && acc_idx == LAST_TAP) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    always_comb begin
        busy_out  = (state != IDLE);
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = '0;
        ram_re    = 1'b0;
        case (state)
            CLEAR: begin
                ram_we    = !reset_in;
                ram_waddr = clr_addr;
            end
            IDLE: begin
                ram_we    = ready_in && !reset_in;
                ram_wdata = signal_in;
            end
            ACCUM:   ram_re = issuing;
            default: ram_re = 1'b0;
        endcase
    end

    // Address arithmetic wraps naturally because DEPTH is a power of two.
    assign ram_raddr = base_q - delay_q[issue_idx];

    always_comb begin
        product = '0;
        if (en_q[acc_idx]) begin
            product = PROD_W'(ram_rdata) * PROD_W'(scale_q[acc_idx]);
        end
    end

    assign result_sat = WIDTH'(sat_shift(64'(acc), FRAC_BITS, WIDTH));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr      <= '0;
            clr_addr    <= '0;
            base_q      <= '0;
            en_q        <= '0;
            issue_idx   <= '0;
            acc_idx     <= '0;
            issuing     <= 1'b0;
            acc_valid   <= 1'b0;
            acc         <= '0;
            signal_out  <= '0;
            done_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            done_out    <= 1'b0;
            overrun_out <= ready_in && (state != IDLE);
            case (state)
                CLEAR: clr_addr <= clr_addr + 1'b1;
                IDLE: begin
                    if (ready_in) begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        base_q    <= wr_ptr;
                        en_q      <= tap_en_in;
                        issue_idx <= '0;
                        issuing   <= 1'b1;
                        acc_valid <= 1'b0;
                        acc       <= '0;
                    end
                end
                ACCUM: begin
                    if (issuing) begin
                        issue_idx <= issue_idx + 1'b1;
                        if (issue_idx == LAST_TAP) begin
                            issuing <= 1'b0;
                        end
                    end
                    acc_valid <= issuing;
                    acc_idx   <= issue_idx;
                    if (acc_valid) begin
                        acc <= acc + ACC_W'(product);
                    end
                end
                OUT: begin
                    signal_out <= result_sat;
                    done_out   <= 1'b1;
                end
                default: done_out <= 1'b0;
            endcase
        end
    end

    // Per-tap configuration is frozen at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk_in) begin
        if (!reset_in && state == IDLE && ready_in) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                delay_q[k] <= delay_in[k*ADDR_W +: ADDR_W];
                scale_q[k] <= scale_in[k*SCALE_W +: SCALE_W];
            end
        end
    end

endmodule

// File: tb/tb_multitap_delay_scale.sv
// Directed bench for multitap_delay_scale: every scenario task drives its own
// vectors and compares against hand-computed values.
module tb_multitap_delay_scale;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 256;
    localparam int NUM_TAPS  = 4;
    localparam int SCALE_W   = 8;
    localparam int FRAC_BITS = 6;
    localparam int ADDR_W    = 8;

    logic                         clk_in = 1'b0;
    logic                         reset_in = 1'b1;
    logic                         ready_in = 1'b0;
    logic [WIDTH-1:0]             signal_in = '0;
    logic [NUM_TAPS*ADDR_W-1:0]   delay_in = '0;
    logic [NUM_TAPS*SCALE_W-1:0]  scale_in = '0;
    logic [NUM_TAPS-1:0]          tap_en_in = '0;
    logic [WIDTH-1:0]             signal_out;
    logic                         done_out;
    logic                         busy_out;
    logic                         overrun_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    multitap_delay_scale #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .NUM_TAPS  (NUM_TAPS),
        .SCALE_W   (SCALE_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .ready_in    (ready_in),
        .signal_in   (signal_in),
        .delay_in    (delay_in),
        .scale_in    (scale_in),
        .tap_en_in   (tap_en_in),
        .signal_out  (signal_out),
        .done_out    (done_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    function automatic logic [31:0] pack4(input logic [7:0] t0, input logic [7:0] t1,
                                          input logic [7:0] t2, input logic [7:0] t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Pulses reset for one edge, then counts edges until the clear sweep ends.
    task automatic do_reset(output int busy_cycles, output bit done_seen);
        reset_in = 1'b1;
        ready_in = 1'b0;
        tick();
        reset_in = 1'b0;
        busy_cycles = 0;
        done_seen = 1'b0;
        while (busy_out && busy_cycles < DEPTH + 20) begin
            tick();
            busy_cycles++;
            if (done_out) done_seen = 1'b1;
        end
    endtask

    // Config and data are scrambled right after acceptance to prove they were latched.
    task automatic send_sample(input logic [15:0] value, input logic [31:0] d,
                               input logic [31:0] s, input logic [3:0] e,
                               output logic [15:0] result, output int lat);
        int guard;
        guard = 0;
        while (busy_out && guard < DEPTH + 20) begin
            tick();
            guard++;
        end
        if (busy_out) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_wait: busy_out=%0b required 0", busy_out);
        end
        signal_in = value;
        delay_in  = d;
        scale_in  = s;
        tap_en_in = e;
        ready_in  = 1'b1;
        tick();
        ready_in  = 1'b0;
        signal_in = ~value;
        delay_in  = ~d;
        scale_in  = ~s;
        tap_en_in = ~e;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done_out && lat < 40);
        if (!done_out) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: done_out=%0b required 1", done_out);
        end
        result = signal_out;
    endtask

    task automatic test_reset();
        int cycles;
        bit done_seen;
        logic [15:0] res;
        int lat;
        reset_in = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy_out, done_out, overrun_out} !== 3'b100 || signal_out !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: busy/done/ovr=%b out=%h required 100 out=0000",
                     {busy_out, done_out, overrun_out}, signal_out);
        end
        reset_in = 1'b0;
        cycles = 0;
        while (busy_out && cycles < DEPTH + 20) begin
            tick();
            cycles++;
        end
        vectors++;
        if (cycles !== DEPTH) begin
            miscompares++;
            $display("[TB] FAIL powerup_busy: %0d cycles required %0d", cycles, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            send_sample(16'h7FFF, pack4(8'd0, 8'd0, 8'd0, 8'd0), pack4(8'd64, 8'd0, 8'd0, 8'd0),
                        4'b0001, res, lat);
        end
        vectors++;
        if (res !== 16'h7FFF) begin
            miscompares++;
            $display("[TB] FAIL fill_echo: got %h required 7fff", res);
        end
        do_reset(cycles, done_seen);
        vectors++;
        if (cycles !== DEPTH) begin
            miscompares++;
            $display("[TB] FAIL clear_busy: %0d cycles required %0d", cycles, DEPTH);
        end
        send_sample(16'h0000, pack4(8'd5, 8'd0, 8'd0, 8'd0), pack4(8'd64, 8'd0, 8'd0, 8'd0),
                    4'b0001, res, lat);
        vectors++;
        if (res !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL clear_delay5: got %h required 0000", res);
        end
        send_sample(16'h0000, pack4(8'd255, 8'd0, 8'd0, 8'd0), pack4(8'd64, 8'd0, 8'd0, 8'd0),
                    4'b0001, res, lat);
        vectors++;
        if (res !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL clear_delay255: got %h required 0000", res);
        end
    endtask

    task automatic test_single_tap();
        int cycles;
        bit done_seen;
        logic [15:0] res;
        logic [15:0] expv;
        int lat;
        do_reset(cycles, done_seen);
        // Disabled taps carry unity gain and delay 0, so a broken enable would show up.
        for (int n = 1; n <= 10; n++) begin
            send_sample(16'(n), pack4(8'd3, 8'd0, 8'd0, 8'd0), pack4(8'd64, 8'd64, 8'd64, 8'd64),
                        4'b0001, res, lat);
            expv = (n > 3) ? 16'(n - 3) : 16'd0;
            vectors++;
            if (res !== expv) begin
                miscompares++;
                $display("[TB] FAIL single_tap n=%0d: got %0d required %0d", n, res, expv);
            end
            vectors++;
            if (lat !== NUM_TAPS + 2) begin
                miscompares++;
                $display("[TB] FAIL latency n=%0d: got %0d required %0d", n, lat, NUM_TAPS + 2);
            end
        end
    endtask

    task automatic test_multi_tap();
        logic [15:0] res;
        int lat;
        logic [31:0] d;
        logic [31:0] s;
        d = pack4(8'd0, 8'd1, 8'd2, 8'd3);
        s = pack4(8'd64, 8'hE0, 8'd16, 8'd1);
        for (int i = 0; i < 6; i++) send_sample(16'd100, d, s, 4'b1111, res, lat);
        // (6400 - 3200 + 1600 + 100) >>> 6 = 76
        vectors++;
        if (res !== 16'd76) begin
            miscompares++;
            $display("[TB] FAIL multi_pos: got %0d required 76", $signed(res));
        end
        for (int i = 0; i < 5; i++) send_sample(-16'sd100, d, s, 4'b1111, res, lat);
        // -4900 >>> 6 floors to -77
        vectors++;
        if (res !== -16'sd77) begin
            miscompares++;
            $display("[TB] FAIL multi_neg: got %0d required -77", $signed(res));
        end
    endtask

    task automatic test_saturation();
        logic [15:0] res;
        int lat;
        logic [31:0] d;
        logic [31:0] s;
        d = pack4(8'd0, 8'd1, 8'd2, 8'd3);
        s = pack4(8'd127, 8'd127, 8'd127, 8'd127);
        for (int i = 0; i < 4; i++) send_sample(16'h7FFF, d, s, 4'b1111, res, lat);
        vectors++;
        if (res !== 16'h7FFF) begin
            miscompares++;
            $display("[TB] FAIL sat_pos: got %h required 7fff", res);
        end
        for (int i = 0; i < 4; i++) send_sample(16'h8000, d, s, 4'b1111, res, lat);
        vectors++;
        if (res !== 16'h8000) begin
            miscompares++;
            $display("[TB] FAIL sat_neg: got %h required 8000", res);
        end
    endtask

    task automatic test_overrun();
        int cycles;
        bit done_seen;
        int lat;
        logic [15:0] res;
        do_reset(cycles, done_seen);
        delay_in  = pack4(8'd1, 8'd0, 8'd0, 8'd0);
        scale_in  = pack4(8'd64, 8'd0, 8'd0, 8'd0);
        tap_en_in = 4'b0001;
        signal_in = 16'd11;
        ready_in  = 1'b1;
        tick();
        ready_in = 1'b0;
        vectors++;
        if (overrun_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovr_accept: got %b required 0", overrun_out);
        end
        tick();
        tick();
        signal_in = 16'd22;
        ready_in  = 1'b1;
        tick();
        ready_in = 1'b0;
        vectors++;
        if (overrun_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovr_drop1: got %b required 1", overrun_out);
        end
        tick();
        vectors++;
        if (overrun_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovr_pulse_width: got %b required 0", overrun_out);
        end
        tick();
        signal_in = 16'd33;
        ready_in  = 1'b1;
        tick();
        ready_in = 1'b0;
        vectors++;
        if ({overrun_out, done_out} !== 2'b11 || signal_out !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL ovr_drop2: ovr/done=%b out=%0d required 11 out=0",
                     {overrun_out, done_out}, signal_out);
        end
        tick();
        tick();
        signal_in = 16'd44;
        ready_in  = 1'b1;
        tick();
        ready_in = 1'b0;
        vectors++;
        if ({overrun_out, busy_out} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL ovr_accept2: ovr/busy=%b required 01", {overrun_out, busy_out});
        end
        lat = 0;
        while (!done_out && lat < 40) begin
            tick();
            lat++;
        end
        vectors++;
        if (signal_out !== 16'd11 || lat !== NUM_TAPS + 2) begin
            miscompares++;
            $display("[TB] FAIL ovr_ptr_hold: out=%0d lat=%0d required out=11 lat=%0d",
                     signal_out, lat, NUM_TAPS + 2);
        end
    endtask

    task automatic test_wrap();
        int cycles;
        bit done_seen;
        int lat;
        logic [15:0] res;
        logic [15:0] expv;
        do_reset(cycles, done_seen);
        for (int i = 0; i < DEPTH + 10; i++) begin
            send_sample(16'(i + 1), pack4(8'd255, 8'd0, 8'd0, 8'd0),
                        pack4(8'd64, 8'd0, 8'd0, 8'd0), 4'b0001, res, lat);
            expv = (i >= DEPTH - 1) ? 16'(i - (DEPTH - 1) + 1) : 16'd0;
            vectors++;
            if (res !== expv) begin
                miscompares++;
                $display("[TB] FAIL wrap i=%0d: got %0d required %0d", i, res, expv);
            end
        end
    endtask

    task automatic test_reset_mid_accum();
        int cycles;
        bit done_seen;
        int lat;
        logic [15:0] res;
        delay_in  = pack4(8'd0, 8'd0, 8'd0, 8'd0);
        scale_in  = pack4(8'd64, 8'd0, 8'd0, 8'd0);
        tap_en_in = 4'b0001;
        signal_in = 16'd500;
        ready_in  = 1'b1;
        tick();
        ready_in = 1'b0;
        tick();
        reset_in = 1'b1;
        tick();
        vectors++;
        if ({done_out, busy_out} !== 2'b01 || signal_out !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_state: done/busy=%b out=%0d required 01 out=0",
                     {done_out, busy_out}, signal_out);
        end
        reset_in = 1'b0;
        cycles = 0;
        done_seen = 1'b0;
        while (busy_out && cycles < DEPTH + 20) begin
            tick();
            cycles++;
            if (done_out) done_seen = 1'b1;
        end
        vectors++;
        if (cycles !== DEPTH || done_seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_clear: %0d cycles done_seen=%b required %0d and 0",
                     cycles, done_seen, DEPTH);
        end
        send_sample(16'd7, pack4(8'd0, 8'd0, 8'd0, 8'd0), pack4(8'd64, 8'd0, 8'd0, 8'd0),
                    4'b0001, res, lat);
        vectors++;
        if (res !== 16'd7) begin
            miscompares++;
            $display("[TB] FAIL post_reset_echo: got %0d required 7", res);
        end
        send_sample(16'd9, pack4(8'd3, 8'd0, 8'd0, 8'd0), pack4(8'd64, 8'd0, 8'd0, 8'd0),
                    4'b0001, res, lat);
        vectors++;
        if (res !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_delay3: got %0d required 0", res);
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_multi_tap();
        test_saturation();
        test_overrun();
        test_wrap();
        test_reset_mid_accum();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
